pll_md_ctrl: RTL and testbench
==============================

# pll_md_ctrl

Sequencer that drives the GW5A PLLA dynamic-modification (MD) port so that logic can rewrite PLL divider registers at runtime. It sits directly upstream of the I2C-clock PLL wrapper and owns that wrapper's `mdopc`/`mdainc`/`mdwdi`/`reset` inputs and its `mdrdo`/`lock` outputs. Clients send single-register write, read or commit requests over a valid/ready handshake. A commit pulses the PLL reset and supervises relock with a timeout.

## Interface
- `RST_CYCLES`, 16: cycles `pll_reset` is held high during a commit (≥1).
- `LOCK_TIMEOUT`, 65535: maximum cycles to wait for `lock` after reset release.
- `LOCK_STABLE`, 8: consecutive synchronized-high `lock` cycles needed to declare lock.
- `clk`  in  1  controller clock; the same net drives the PLL `mdclk`.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_cmd`  in  2  00 write, 01 read, 10 commit, 11 treated as NOP (responds with error).
- `req_addr`  in  8  MD register address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; 0 for non-reads.
- `rsp_err`  out  1  set with `rsp_valid` on lock timeout or illegal command.
- `busy`  out  1  high whenever the state is not IDLE.
- `mdopc`  out  2  to PLL: 00 NOP, 01 write, 10 read, 11 address load.
- `mdainc`  out  1  to PLL; always 0 (no auto-increment in this block).
- `mdwdi`  out  8  to PLL.
- `mdrdo`  in  8  from PLL.
- `pll_reset`  out  1  to PLL `reset`.
- `lock`  in  1  from PLL; asynchronous.

## Operation
- States: IDLE, ADDR, DATA, RDWAIT, RSP, PRST, WLOCK.
- IDLE: `req_ready`=1. On `req_valid`, latch cmd/addr/wdata.
  - cmd 00 or 01 → ADDR.
  - cmd 10 → PRST.
  - cmd 11 → RSP with err=1.
- ADDR: `mdopc`=11, `mdwdi`=addr → DATA.
- DATA: `mdopc`=01 with `mdwdi`=wdata (write) → RSP; or `mdopc`=10 with `mdwdi`=0 (read) → RDWAIT.
- RDWAIT: `mdopc`=00; sample `mdrdo` into `rsp_rdata` at the end of this cycle → RSP.
- RSP: `rsp_valid`=1 for exactly one cycle → IDLE.
- PRST: `pll_reset`=1, counter runs 0..RST_CYCLES-1 → WLOCK.
- WLOCK: `pll_reset`=0.
  - `lock` passes through a 2-FF synchronizer.
  - Stable counter increments while synced lock=1 and clears to 0 on any 0.
  - Reaching LOCK_STABLE → RSP with err=0.
  - Timeout counter reaching LOCK_TIMEOUT first → RSP with err=1.
  - A lock that drops before it is declared stable does not abort; the stable count simply restarts.
- `mdopc`=00 and `mdwdi`=0 in every state other than ADDR and DATA.
- Counters are 17 bits, saturating, and cleared on state entry.
- Reset values: `req_ready` 0 during reset, 1 from the first cycle after. All other outputs 0, including `pll_reset`, `mdopc` and `mdainc`. Synchronizer flops and all counters 0.
- Reset mid-operation: any state returns to IDLE on the next edge. An MD transaction in flight is abandoned (`mdopc` returns to 00), no response is generated, and `pll_reset` drops.

## Timing
- Accept edge A = the edge where `req_valid & req_ready`.
- Write: ADDR in cycle A+1, DATA in A+2, `rsp_valid` in A+3.
- Read: ADDR in A+1, DATA in A+2, RDWAIT in A+3, `rsp_valid` with data in A+4.
- Commit: `pll_reset` high for cycles A+1 .. A+RST_CYCLES. `rsp_valid` comes at the earliest 2+LOCK_STABLE cycles after reset release, and at the latest LOCK_TIMEOUT+1 cycles after reset release.
- Back-to-back: `req_ready` returns in the cycle after `rsp_valid`, so throughput is one write per 4 cycles.
- `req_*` inputs are ignored when `req_ready`=0.

## Structure
- Shared package `pll_md_pkg` holds:
  - MD opcode constants (NOP/WR/RD/ADDR).
  - `req_cmd` encodings.
  - The state enum.
- Sub-module `lock_sync`: 2-FF synchronizer plus stable counter. Outputs `lock_stable`; cleared by `reset` or a `clr` input asserted on WLOCK entry.
- The top level instantiates this block beside the PLL wrapper, with its `mdclk` tied to `clk`.

## Test plan
- Write addr 0x12, data 0x5A: `mdopc` sequence 11/01 in A+1/A+2 with `mdwdi` 0x12/0x5A. `rsp_valid` at A+3 with err=0 and rdata=0.
- Read addr 0x34 with the model driving `mdrdo`=0xC3 from A+3: `mdopc` 11/10/00, then `rsp_rdata`=0xC3 with `rsp_valid` at A+4.
- Commit with RST_CYCLES=4, LOCK_STABLE=8, and `lock` rising 10 cycles after release:
  - `pll_reset` high for exactly 4 cycles.
  - Response with err=0 at release+10+2+8.
- Commit where `lock` never rises, LOCK_TIMEOUT=100: `rsp_err`=1 at release+101. A lock glitch of 3 cycles mid-wait restarts the stable count and does not complete the commit.
- `reset` asserted during DATA of a write and again during PRST: no `rsp_valid`, `mdopc`=00 and `pll_reset`=0 on the next edge, and `req_ready`=1 the cycle after reset falls.
- `req_cmd`=11 → `rsp_valid` at A+1 with err=1. Random `req_valid` while busy is ignored: no extra MD traffic and no extra responses.

Source files
------------

// File: rtl/pll_md_pkg.sv
// Shared definitions for the PLL dynamic-modification sequencer: MD opcodes,
// client command encodings, FSM state type and a saturating counter helper.
package pll_md_pkg;

  localparam int CNT_W = 17;

  localparam logic [1:0] MD_NOP  = 2'b00;
  localparam logic [1:0] MD_WR   = 2'b01;
  localparam logic [1:0] MD_RD   = 2'b10;
  localparam logic [1:0] MD_ADDR = 2'b11;

  localparam logic [1:0] CMD_WR     = 2'b00;
  localparam logic [1:0] CMD_RD     = 2'b01;
  localparam logic [1:0] CMD_COMMIT = 2'b10;
  localparam logic [1:0] CMD_NOP    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RDWAIT,
    ST_RSP,
    ST_PRST,
    ST_WLOCK
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pll_md_if.sv
// Client request/response channel of the PLL MD sequencer.
interface pll_md_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pll_md_ctrl_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock plus a run-length counter
// that declares lock once it has been continuously high for LOCK_STABLE cycles.
module lock_sync
  import pll_md_pkg::*;
#(
  parameter int LOCK_STABLE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic lock,
  output logic lock_stable
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= lock;
      sync2 <= sync1;
      if (sync2) cnt <= sat_inc(cnt);
      else       cnt <= '0;
    end
  end

  // Asserted in the cycle whose closing edge completes the stable run, so the
  // FSM leaves WLOCK on that same edge.
  assign lock_stable = sync2 && (cnt >= STABLE_LAST);

endmodule

// File: rtl/pll_md_ctrl.sv
// Sequencer for the PLL dynamic-modification port: single register writes and
// reads, plus a commit that pulses the PLL reset and supervises relock.
module pll_md_ctrl
  import pll_md_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 8
) (
  input  logic       clk,
  input  logic       reset,
  pll_md_if.slave    host,
  output logic       busy,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  output logic       pll_reset,
  input  logic       lock
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(LOCK_TIMEOUT);

  state_t           state;
  logic [1:0]       cmd_q;
  logic [7:0]       wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             lock_clr;
  logic             lock_stable;

  // Clear the lock monitor on the edge that enters WLOCK so stale history
  // from before the PLL reset cannot count towards the stable run.
  assign lock_clr = (state == ST_PRST) && (cnt >= RST_LAST);
  assign busy     = (state != ST_IDLE);
  assign mdainc   = 1'b0;

  lock_sync #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_sync (
    .clk         (clk),
    .reset       (reset),
    .clr         (lock_clr),
    .lock        (lock),
    .lock_stable (lock_stable)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cmd_q          <= CMD_WR;
      wdata_q        <= '0;
      cnt            <= '0;
      mdopc          <= MD_NOP;
      mdwdi          <= '0;
      pll_reset      <= 1'b0;
      host.req_ready <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
      host.rsp_err   <= 1'b0;
    end else begin
      mdopc          <= MD_NOP;
      mdwdi          <= '0;
      pll_reset      <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
      host.rsp_err   <= 1'b0;
      cnt            <= sat_inc(cnt);

      case (state)
        ST_IDLE: begin
          host.req_ready <= 1'b1;
          if (host.req_valid && host.req_ready) begin
            host.req_ready <= 1'b0;
            cmd_q          <= host.req_cmd;
            wdata_q        <= host.req_wdata;
            cnt            <= '0;
            case (host.req_cmd)
              CMD_WR, CMD_RD: begin
                state <= ST_ADDR;
                mdopc <= MD_ADDR;
                mdwdi <= host.req_addr;
              end
              CMD_COMMIT: begin
                state     <= ST_PRST;
                pll_reset <= 1'b1;
              end
              default: begin
                state          <= ST_RSP;
                host.rsp_valid <= 1'b1;
                host.rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        ST_ADDR: begin
          state <= ST_DATA;
          cnt   <= '0;
          if (cmd_q == CMD_WR) begin
            mdopc <= MD_WR;
            mdwdi <= wdata_q;
          end else begin
            mdopc <= MD_RD;
          end
        end

        ST_DATA: begin
          cnt <= '0;
          if (cmd_q == CMD_WR) begin
            state          <= ST_RSP;
            host.rsp_valid <= 1'b1;
          end else begin
            state <= ST_RDWAIT;
          end
        end

        ST_RDWAIT: begin
          state          <= ST_RSP;
          cnt            <= '0;
          host.rsp_valid <= 1'b1;
          host.rsp_rdata <= mdrdo;
        end

        ST_RSP: begin
          state          <= ST_IDLE;
          cnt            <= '0;
          host.req_ready <= 1'b1;
        end

        ST_PRST: begin
          if (cnt >= RST_LAST) begin
            state <= ST_WLOCK;
            cnt   <= '0;
          end else begin
            pll_reset <= 1'b1;
          end
        end

        ST_WLOCK: begin
          if (lock_stable) begin
            state          <= ST_RSP;
            cnt            <= '0;
            host.rsp_valid <= 1'b1;
          end else if (cnt >= TIMEOUT_C) begin
            state          <= ST_RSP;
            cnt            <= '0;
            host.rsp_valid <= 1'b1;
            host.rsp_err   <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_md_ctrl.sv
// Directed bench for pll_md_ctrl: writes, reads, commits with lock and timeout,
// mid-operation reset, illegal command and request noise while busy.
module tb_pll_md_ctrl;
  import pll_md_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;
  logic       pll_reset;
  logic       lock;

  int n_checks = 0;
  int n_errors = 0;

  pll_md_if bus ();

  pll_md_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .LOCK_STABLE  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (bus),
    .busy      (busy),
    .mdopc     (mdopc),
    .mdainc    (mdainc),
    .mdwdi     (mdwdi),
    .mdrdo     (mdrdo),
    .pll_reset (pll_reset),
    .lock      (lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request in the current (idle) cycle; returns in cycle A+1.
  task automatic issue(input logic [1:0] cmd, input logic [7:0] addr, input logic [7:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Commit up to the first cycle after PLL reset release.
  task automatic commit_to_release(input string tag);
    int highs;
    highs = 0;
    issue(CMD_COMMIT, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (pll_reset) highs++;
      step();
    end
    chk({tag, "_prst_cycles"}, highs, 4);
    chk({tag, "_released"}, int'(pll_reset), 0);
  endtask

  initial begin
    int lat;
    int rsp_cnt;
    int md_cnt;
    logic err_seen;

    reset         = 1'b1;
    lock          = 1'b0;
    mdrdo         = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    repeat (3) step();

    chk("rst_ready",   int'(bus.req_ready), 0);
    chk("rst_mdopc",   int'(mdopc), 0);
    chk("rst_pllrst",  int'(pll_reset), 0);
    chk("rst_rspv",    int'(bus.rsp_valid), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_mdainc",  int'(mdainc), 0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", int'(bus.req_ready), 1);

    // write 0x12 <- 0x5A
    issue(CMD_WR, 8'h12, 8'h5A);
    chk("wr_a1_opc",  int'(mdopc), 3);
    chk("wr_a1_wdi",  int'(mdwdi), 8'h12);
    chk("wr_a1_busy", int'(busy), 1);
    step();
    chk("wr_a2_opc",  int'(mdopc), 1);
    chk("wr_a2_wdi",  int'(mdwdi), 8'h5A);
    chk("wr_a2_rspv", int'(bus.rsp_valid), 0);
    step();
    chk("wr_a3_rspv",  int'(bus.rsp_valid), 1);
    chk("wr_a3_err",   int'(bus.rsp_err), 0);
    chk("wr_a3_rdata", int'(bus.rsp_rdata), 0);
    chk("wr_a3_opc",   int'(mdopc), 0);
    step();
    chk("wr_a4_ready", int'(bus.req_ready), 1);
    chk("wr_a4_rspv",  int'(bus.rsp_valid), 0);

    // read 0x34, PLL returns 0xC3 during RDWAIT
    issue(CMD_RD, 8'h34, 8'hFF);
    chk("rd_a1_opc", int'(mdopc), 3);
    chk("rd_a1_wdi", int'(mdwdi), 8'h34);
    step();
    chk("rd_a2_opc", int'(mdopc), 2);
    chk("rd_a2_wdi", int'(mdwdi), 0);
    step();
    chk("rd_a3_opc",  int'(mdopc), 0);
    chk("rd_a3_rspv", int'(bus.rsp_valid), 0);
    mdrdo = 8'hC3;
    step();
    mdrdo = 8'h55;
    chk("rd_a4_rspv",  int'(bus.rsp_valid), 1);
    chk("rd_a4_rdata", int'(bus.rsp_rdata), 8'hC3);
    chk("rd_a4_err",   int'(bus.rsp_err), 0);
    step();
    chk("rd_a5_rdata", int'(bus.rsp_rdata), 0);
    chk("rd_a5_ready", int'(bus.req_ready), 1);

    // commit, lock rises 10 cycles after release
    commit_to_release("cmt");
    lat = -1;
    err_seen = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (k == 10) lock = 1'b1;
      if (bus.rsp_valid) begin
        lat = k;
        err_seen = bus.rsp_err;
        break;
      end
      step();
    end
    chk("cmt_lat", lat, 20);
    chk("cmt_err", int'(err_seen), 0);
    lock = 1'b0;
    step();
    chk("cmt_ready", int'(bus.req_ready), 1);

    // commit, lock never settles (3-cycle glitch), timeout
    commit_to_release("tmo");
    lat = -1;
    err_seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == 30) lock = 1'b1;
      if (k == 33) lock = 1'b0;
      if (bus.rsp_valid) begin
        lat = k;
        err_seen = bus.rsp_err;
        break;
      end
      step();
    end
    chk("tmo_lat", lat, 101);
    chk("tmo_err", int'(err_seen), 1);
    step();

    // reset during DATA of a write
    issue(CMD_WR, 8'h21, 8'h43);
    step();
    chk("rstd_in_data", int'(mdopc), 1);
    reset = 1'b1;
    step();
    chk("rstd_opc",  int'(mdopc), 0);
    chk("rstd_rspv", int'(bus.rsp_valid), 0);
    chk("rstd_busy", int'(busy), 0);
    reset = 1'b0;
    step();
    chk("rstd_ready", int'(bus.req_ready), 1);
    chk("rstd_norsp", int'(bus.rsp_valid), 0);

    // reset during PRST
    issue(CMD_COMMIT, 8'h00, 8'h00);
    step();
    chk("rstp_in_prst", int'(pll_reset), 1);
    reset = 1'b1;
    step();
    chk("rstp_pllrst", int'(pll_reset), 0);
    chk("rstp_rspv",   int'(bus.rsp_valid), 0);
    reset = 1'b0;
    step();
    chk("rstp_ready", int'(bus.req_ready), 1);
    chk("rstp_norsp", int'(bus.rsp_valid), 0);

    // illegal command
    issue(CMD_NOP, 8'h77, 8'h88);
    chk("nop_rspv", int'(bus.rsp_valid), 1);
    chk("nop_err",  int'(bus.rsp_err), 1);
    chk("nop_opc",  int'(mdopc), 0);
    step();
    chk("nop_ready", int'(bus.req_ready), 1);

    // write with random request noise while busy
    rsp_cnt = 0;
    md_cnt  = 0;
    issue(CMD_WR, 8'h66, 8'h99);
    for (int k = 1; k <= 8; k++) begin
      if (bus.rsp_valid) rsp_cnt++;
      if (mdopc != 2'b00) md_cnt++;
      if (k == 2) chk("noise_a2_wdi", int'(mdwdi), 8'h99);
      if (k <= 2) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_cmd   = 2'($urandom_range(0, 3));
        bus.req_addr  = 8'($urandom_range(0, 255));
        bus.req_wdata = 8'($urandom_range(0, 255));
      end else begin
        bus.req_valid = 1'b0;
      end
      step();
    end
    chk("noise_rsp_cnt", rsp_cnt, 1);
    chk("noise_md_cnt",  md_cnt, 2);
    chk("noise_idle",    int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
